// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the ID/EX stage.
//   - datapath / field width constants
//   - primary opcode constants (instruction [31:26])
//   - funct / ALU-operation constants (instruction [5:0] and ALU select)
package mips_pkg;

   localparam int W_DATA = 32;
   localparam int W_OP   = 6;
   localparam int W_REG  = 5;
   localparam int W_IMM  = 16;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // funct field values, reused as ALU operation codes
   localparam logic [5:0] ALU_SLL  = 6'b000000;
   localparam logic [5:0] ALU_SRL  = 6'b000010;
   localparam logic [5:0] ALU_SRA  = 6'b000011;
   localparam logic [5:0] ALU_SLLV = 6'b000100;
   localparam logic [5:0] ALU_SRLV = 6'b000110;
   localparam logic [5:0] ALU_SRAV = 6'b000111;
   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_ADDU = 6'b100001;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [5:0] ALU_SUBU = 6'b100011;
   localparam logic [5:0] ALU_AND  = 6'b100100;
   localparam logic [5:0] ALU_OR   = 6'b100101;
   localparam logic [5:0] ALU_XOR  = 6'b100110;
   localparam logic [5:0] ALU_NOR  = 6'b100111;
   localparam logic [5:0] ALU_SLT  = 6'b101010;
   // Unrecognised instruction: the ALU produces 0 for this select
   localparam logic [5:0] ALU_NONE = 6'b111111;

endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: selects the freshest value of one source register.
//   i_addr            source register address
//   i_rf_data         value read from the register file in decode
//   i_exmem_*         EX/MEM write port (regwrite, addr, data)
//   i_memwb_*         MEM/WB write port (regwrite, addr, data)
//   o_data            EX/MEM result, else MEM/WB result, else i_rf_data
// Register 0 is hard-wired to zero and is never forwarded.
module forwarding_unit
   import mips_pkg::*;
#(
   parameter int SIZEDATA = W_DATA,
   parameter int SIZEREG  = W_REG
) (
   input  logic [SIZEREG-1:0]  i_addr,
   input  logic [SIZEDATA-1:0] i_rf_data,
   input  logic                i_exmem_regwrite,
   input  logic [SIZEREG-1:0]  i_exmem_addr,
   input  logic [SIZEDATA-1:0] i_exmem_data,
   input  logic                i_memwb_regwrite,
   input  logic [SIZEREG-1:0]  i_memwb_addr,
   input  logic [SIZEDATA-1:0] i_memwb_data,
   output logic [SIZEDATA-1:0] o_data
);

   logic addr_nz;
   logic hit_exmem;
   logic hit_memwb;

   always_comb begin
      addr_nz   = (i_addr != '0);
      hit_exmem = i_exmem_regwrite && (i_exmem_addr == i_addr) && addr_nz;
      hit_memwb = i_memwb_regwrite && (i_memwb_addr == i_addr) && addr_nz;
      // EX/MEM holds the younger result, so it wins over MEM/WB
      if (hit_exmem)      o_data = i_exmem_data;
      else if (hit_memwb) o_data = i_memwb_data;
      else                o_data = i_rf_data;
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus operand/forwarding selection.
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_stall, i_flush      hold all registers / load a bubble (flush wins)
//   i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs/rt/rd_addr,
//   i_rs/rt_data, i_regdst, i_regwrite, i_memread, i_memwrite, i_memtoreg
//                         decode fields captured at the rising edge
//   i_exmem_*, i_memwb_*  forwarding ports, used live (not registered)
//   o_alu_datoa/datob     ALU operands; o_alu_opcode ALU operation
//   o_store_data          forwarded rt value for stores
//   o_wr_addr             destination register (rd if regdst, else rt)
//   o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg  to EX/MEM
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int SIZEDATA = W_DATA,
   parameter int SIZEOP   = W_OP,
   parameter int SIZEREG  = W_REG,
   parameter int SIZEIMM  = W_IMM
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic                i_valid,
   input  logic [SIZEOP-1:0]   i_opcode,
   input  logic [SIZEOP-1:0]   i_funct,
   input  logic [SIZEREG-1:0]  i_shamt,
   input  logic [SIZEIMM-1:0]  i_imm,
   input  logic [SIZEREG-1:0]  i_rs_addr,
   input  logic [SIZEREG-1:0]  i_rt_addr,
   input  logic [SIZEREG-1:0]  i_rd_addr,
   input  logic [SIZEDATA-1:0] i_rs_data,
   input  logic [SIZEDATA-1:0] i_rt_data,
   input  logic                i_regdst,
   input  logic                i_regwrite,
   input  logic                i_memread,
   input  logic                i_memwrite,
   input  logic                i_memtoreg,
   input  logic                i_exmem_regwrite,
   input  logic [SIZEREG-1:0]  i_exmem_addr,
   input  logic [SIZEDATA-1:0] i_exmem_data,
   input  logic                i_memwb_regwrite,
   input  logic [SIZEREG-1:0]  i_memwb_addr,
   input  logic [SIZEDATA-1:0] i_memwb_data,
   output logic [SIZEDATA-1:0] o_alu_datoa,
   output logic [SIZEDATA-1:0] o_alu_datob,
   output logic [SIZEOP-1:0]   o_alu_opcode,
   output logic [SIZEDATA-1:0] o_store_data,
   output logic [SIZEREG-1:0]  o_wr_addr,
   output logic                o_valid,
   output logic                o_regwrite,
   output logic                o_memread,
   output logic                o_memwrite,
   output logic                o_memtoreg
);

   localparam logic [SIZEDATA-1:0] LUI_SHIFT = SIZEDATA'(16);

   logic [SIZEOP-1:0]   opcode_d, opcode_q, funct_d, funct_q;
   logic [SIZEREG-1:0]  shamt_d, shamt_q, rs_addr_d, rs_addr_q;
   logic [SIZEREG-1:0]  rt_addr_d, rt_addr_q, rd_addr_d, rd_addr_q;
   logic [SIZEIMM-1:0]  imm_d, imm_q;
   logic [SIZEDATA-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q;
   logic valid_d, valid_q, regdst_d, regdst_q, regwrite_d, regwrite_q;
   logic memread_d, memread_q, memwrite_d, memwrite_q, memtoreg_d, memtoreg_q;

   always_comb begin
      opcode_d   = opcode_q;   funct_d    = funct_q;
      shamt_d    = shamt_q;    imm_d      = imm_q;
      rs_addr_d  = rs_addr_q;  rt_addr_d  = rt_addr_q;
      rd_addr_d  = rd_addr_q;  rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;  regdst_d   = regdst_q;
      valid_d    = valid_q;    regwrite_d = regwrite_q;
      memread_d  = memread_q;  memwrite_d = memwrite_q;
      memtoreg_d = memtoreg_q;
      if (i_flush) begin
         // Bubble: only the control bits matter; data fields are don't-care
         valid_d    = 1'b0;  regwrite_d = 1'b0;  memread_d = 1'b0;
         memwrite_d = 1'b0;  memtoreg_d = 1'b0;
      end else if (!i_stall) begin
         opcode_d   = i_opcode;   funct_d    = i_funct;
         shamt_d    = i_shamt;    imm_d      = i_imm;
         rs_addr_d  = i_rs_addr;  rt_addr_d  = i_rt_addr;
         rd_addr_d  = i_rd_addr;  rs_data_d  = i_rs_data;
         rt_data_d  = i_rt_data;  regdst_d   = i_regdst;
         valid_d    = i_valid;    regwrite_d = i_regwrite;
         memread_d  = i_memread;  memwrite_d = i_memwrite;
         memtoreg_d = i_memtoreg;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         opcode_q   <= '0;  funct_q    <= '0;  shamt_q    <= '0;
         imm_q      <= '0;  rs_addr_q  <= '0;  rt_addr_q  <= '0;
         rd_addr_q  <= '0;  rs_data_q  <= '0;  rt_data_q  <= '0;
         regdst_q   <= 1'b0; valid_q   <= 1'b0; regwrite_q <= 1'b0;
         memread_q  <= 1'b0; memwrite_q <= 1'b0; memtoreg_q <= 1'b0;
      end else begin
         opcode_q   <= opcode_d;   funct_q    <= funct_d;
         shamt_q    <= shamt_d;    imm_q      <= imm_d;
         rs_addr_q  <= rs_addr_d;  rt_addr_q  <= rt_addr_d;
         rd_addr_q  <= rd_addr_d;  rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;  regdst_q   <= regdst_d;
         valid_q    <= valid_d;    regwrite_q <= regwrite_d;
         memread_q  <= memread_d;  memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
      end
   end

   // Execute side: forwarding uses the live EX/MEM and MEM/WB ports
   logic [SIZEDATA-1:0] rs_fwd, rt_fwd;

   forwarding_unit #(.SIZEDATA(SIZEDATA), .SIZEREG(SIZEREG)) u_fwd_rs (
      .i_addr(rs_addr_q), .i_rf_data(rs_data_q),
      .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_addr(i_exmem_addr),
      .i_exmem_data(i_exmem_data),
      .i_memwb_regwrite(i_memwb_regwrite), .i_memwb_addr(i_memwb_addr),
      .i_memwb_data(i_memwb_data), .o_data(rs_fwd)
   );

   forwarding_unit #(.SIZEDATA(SIZEDATA), .SIZEREG(SIZEREG)) u_fwd_rt (
      .i_addr(rt_addr_q), .i_rf_data(rt_data_q),
      .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_addr(i_exmem_addr),
      .i_exmem_data(i_exmem_data),
      .i_memwb_regwrite(i_memwb_regwrite), .i_memwb_addr(i_memwb_addr),
      .i_memwb_data(i_memwb_data), .o_data(rt_fwd)
   );

   logic [SIZEDATA-1:0] imm_sext, imm_zext, shamt_zext, rs_low_zext;

   always_comb begin
      imm_sext    = {{(SIZEDATA-SIZEIMM){imm_q[SIZEIMM-1]}}, imm_q};
      imm_zext    = {{(SIZEDATA-SIZEIMM){1'b0}}, imm_q};
      shamt_zext  = {{(SIZEDATA-SIZEREG){1'b0}}, shamt_q};
      // Variable shifts take their amount from the low bits of rs
      rs_low_zext = {{(SIZEDATA-SIZEREG){1'b0}}, rs_fwd[SIZEREG-1:0]};

      o_alu_opcode = ALU_NONE;
      o_alu_datoa  = '0;
      o_alu_datob  = '0;
      case (opcode_q)
         OP_RTYPE: begin
            o_alu_opcode = funct_q;
            case (funct_q)
               ALU_SLL, ALU_SRL, ALU_SRA: begin
                  o_alu_datoa = rt_fwd;  o_alu_datob = shamt_zext;
               end
               ALU_SLLV, ALU_SRLV, ALU_SRAV: begin
                  o_alu_datoa = rt_fwd;  o_alu_datob = rs_low_zext;
               end
               default: begin
                  o_alu_datoa = rs_fwd;  o_alu_datob = rt_fwd;
               end
            endcase
         end
         OP_ADDI, OP_SLTI: begin
            o_alu_opcode = opcode_q;  o_alu_datoa = rs_fwd;  o_alu_datob = imm_sext;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            o_alu_opcode = opcode_q;  o_alu_datoa = rs_fwd;  o_alu_datob = imm_zext;
         end
         OP_LUI: begin
            // ALU shifts the immediate left by 16
            o_alu_opcode = OP_LUI;  o_alu_datoa = imm_zext;  o_alu_datob = LUI_SHIFT;
         end
         OP_LW, OP_SW: begin
            o_alu_opcode = ALU_ADDU;  o_alu_datoa = rs_fwd;  o_alu_datob = imm_sext;
         end
         default: ;
      endcase

      o_store_data = rt_fwd;
      o_wr_addr    = regdst_q ? rd_addr_q : rt_addr_q;
      o_valid      = valid_q;
      o_regwrite   = regwrite_q;
      o_memread    = memread_q;
      o_memwrite   = memwrite_q;
      o_memtoreg   = memtoreg_q;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   typedef struct {
      logic [5:0]  op, funct;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd;
      logic        regdst, rw, mr, mw, mt;
      logic        exw;  logic [4:0] exa;  logic [31:0] exd;
      logic        mww;  logic [4:0] mwa;  logic [31:0] mwd;
      logic [31:0] ea, eb, est;
      logic [5:0]  eop;
      logic [4:0]  ewr;
      bit          ops;   // operands defined for this instruction
   } vec_t;

   logic        i_clk = 0, i_reset, i_stall, i_flush, i_valid;
   logic [5:0]  i_opcode, i_funct;
   logic [4:0]  i_shamt, i_rs_addr, i_rt_addr, i_rd_addr;
   logic [15:0] i_imm;
   logic [31:0] i_rs_data, i_rt_data;
   logic        i_regdst, i_regwrite, i_memread, i_memwrite, i_memtoreg;
   logic        i_exmem_regwrite, i_memwb_regwrite;
   logic [4:0]  i_exmem_addr, i_memwb_addr;
   logic [31:0] i_exmem_data, i_memwb_data;
   logic [31:0] o_alu_datoa, o_alu_datob, o_store_data;
   logic [5:0]  o_alu_opcode;
   logic [4:0]  o_wr_addr;
   logic        o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg;

   int n_vec = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   id_ex_stage dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
      .i_valid(i_valid), .i_opcode(i_opcode), .i_funct(i_funct),
      .i_shamt(i_shamt), .i_imm(i_imm), .i_rs_addr(i_rs_addr),
      .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr), .i_rs_data(i_rs_data),
      .i_rt_data(i_rt_data), .i_regdst(i_regdst), .i_regwrite(i_regwrite),
      .i_memread(i_memread), .i_memwrite(i_memwrite), .i_memtoreg(i_memtoreg),
      .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_addr(i_exmem_addr),
      .i_exmem_data(i_exmem_data), .i_memwb_regwrite(i_memwb_regwrite),
      .i_memwb_addr(i_memwb_addr), .i_memwb_data(i_memwb_data),
      .o_alu_datoa(o_alu_datoa), .o_alu_datob(o_alu_datob),
      .o_alu_opcode(o_alu_opcode), .o_store_data(o_store_data),
      .o_wr_addr(o_wr_addr), .o_valid(o_valid), .o_regwrite(o_regwrite),
      .o_memread(o_memread), .o_memwrite(o_memwrite), .o_memtoreg(o_memtoreg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(logic [5:0] op, logic [5:0] funct, logic [4:0] shamt,
                                logic [15:0] imm, logic [4:0] rs, logic [4:0] rt,
                                logic [31:0] rsd, logic [31:0] rtd);
      vec_t v;
      v.op = op; v.funct = funct; v.shamt = shamt; v.imm = imm;
      v.rs = rs; v.rt = rt; v.rd = 5'd0; v.rsd = rsd; v.rtd = rtd;
      v.regdst = 0; v.rw = 1; v.mr = 0; v.mw = 0; v.mt = 0;
      v.exw = 0; v.exa = 0; v.exd = 0; v.mww = 0; v.mwa = 0; v.mwd = 0;
      v.ea = 0; v.eb = 0; v.est = rtd; v.eop = 0; v.ewr = rt; v.ops = 1;
      return v;
   endfunction

   // Reference model: newest writer of a nonzero register supplies its value
   function automatic logic [31:0] ref_src(vec_t v, logic [4:0] r, logic [31:0] rf);
      if (r == 0) return rf;
      if (v.exw && v.exa == r) return v.exd;
      if (v.mww && v.mwa == r) return v.mwd;
      return rf;
   endfunction

   function automatic vec_t ref_model(vec_t vin);
      vec_t v = vin;
      logic [31:0] rs_v, rt_v, sx, zx;
      rs_v = ref_src(v, v.rs, v.rsd);
      rt_v = ref_src(v, v.rt, v.rtd);
      zx = 32'(v.imm);
      sx = (v.imm >= 16'h8000) ? zx + 32'hFFFF_0000 : zx;
      v.est = rt_v;
      v.ewr = v.regdst ? v.rd : v.rt;
      v.ops = 1;
      case (v.op)
         6'h00: begin
            v.eop = v.funct;
            if (v.funct inside {6'h00, 6'h02, 6'h03}) begin v.ea = rt_v; v.eb = 32'(v.shamt); end
            else if (v.funct inside {6'h04, 6'h06, 6'h07}) begin v.ea = rt_v; v.eb = rs_v % 32; end
            else begin v.ea = rs_v; v.eb = rt_v; end
         end
         6'h08, 6'h0A:        begin v.eop = v.op;  v.ea = rs_v; v.eb = sx; end
         6'h0C, 6'h0D, 6'h0E: begin v.eop = v.op;  v.ea = rs_v; v.eb = zx; end
         6'h0F:               begin v.eop = 6'h0F; v.ea = zx;   v.eb = 16; end
         6'h23, 6'h2B:        begin v.eop = 6'h21; v.ea = rs_v; v.eb = sx; end
         default:             begin v.eop = 6'h3F; v.ops = 0; end
      endcase
      return v;
   endfunction

   task automatic drive_dec(vec_t v);
      i_valid = 1; i_opcode = v.op; i_funct = v.funct; i_shamt = v.shamt;
      i_imm = v.imm; i_rs_addr = v.rs; i_rt_addr = v.rt; i_rd_addr = v.rd;
      i_rs_data = v.rsd; i_rt_data = v.rtd; i_regdst = v.regdst;
      i_regwrite = v.rw; i_memread = v.mr; i_memwrite = v.mw; i_memtoreg = v.mt;
   endtask

   task automatic drive_fwd(vec_t v);
      i_exmem_regwrite = v.exw; i_exmem_addr = v.exa; i_exmem_data = v.exd;
      i_memwb_regwrite = v.mww; i_memwb_addr = v.mwa; i_memwb_data = v.mwd;
   endtask

   task automatic check_out(vec_t v, string tag);
      chk({tag, ".opcode"}, 32'(o_alu_opcode), 32'(v.eop));
      if (v.ops) begin
         chk({tag, ".datoa"}, o_alu_datoa, v.ea);
         chk({tag, ".datob"}, o_alu_datob, v.eb);
      end
      chk({tag, ".store"}, o_store_data, v.est);
      chk({tag, ".wr_addr"}, 32'(o_wr_addr), 32'(v.ewr));
      chk({tag, ".ctrl"}, {27'd0, o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg},
          {27'd0, 1'b1, v.rw, v.mr, v.mw, v.mt});
   endtask

   // Load in cycle N, present forwarding in cycle N+1, then compare
   task automatic load_vec(vec_t v, string tag);
      i_stall = 0; i_flush = 0;
      drive_dec(v);
      @(posedge i_clk); #1;
      drive_fwd(v); #1;
      check_out(v, tag);
   endtask

   task automatic check_zero(string tag);
      chk({tag, ".opcode"}, 32'(o_alu_opcode), 32'd0);
      chk({tag, ".datoa"}, o_alu_datoa, 32'd0);
      chk({tag, ".datob"}, o_alu_datob, 32'd0);
      chk({tag, ".store"}, o_store_data, 32'd0);
      chk({tag, ".wr_addr"}, 32'(o_wr_addr), 32'd0);
      chk({tag, ".ctrl"}, {27'd0, o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg}, 32'd0);
   endtask

   vec_t tbl[10];
   vec_t v, vs, vx;
   logic [5:0] ops_list[9] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

   initial begin
      // Directed vectors with hand-computed expectations
      tbl[0] = mkv(6'h08, 0, 0, 16'hFFFF, 5, 7, 32'h10, 32'h3);
      tbl[0].ea = 32'h10; tbl[0].eb = 32'hFFFF_FFFF; tbl[0].eop = 6'h08;
      tbl[1] = mkv(6'h0D, 0, 0, 16'hFFFF, 5, 7, 32'h10, 32'h3);
      tbl[1].ea = 32'h10; tbl[1].eb = 32'h0000_FFFF; tbl[1].eop = 6'h0D;
      tbl[2] = mkv(6'h0F, 0, 0, 16'h1234, 0, 8, 32'h0, 32'h0);
      tbl[2].ea = 32'h1234; tbl[2].eb = 32'd16; tbl[2].eop = 6'h0F;
      tbl[3] = mkv(6'h00, 6'h00, 4, 0, 0, 2, 32'h0, 32'h1);
      tbl[3].ea = 32'h1; tbl[3].eb = 32'h4; tbl[3].eop = 6'h00;
      tbl[4] = mkv(6'h00, 6'h21, 0, 0, 3, 3, 32'h1, 32'h1);
      tbl[4].exw = 1; tbl[4].exa = 3; tbl[4].exd = 32'hAA;
      tbl[4].mww = 1; tbl[4].mwa = 3; tbl[4].mwd = 32'hBB;
      tbl[4].ea = 32'hAA; tbl[4].eb = 32'hAA; tbl[4].est = 32'hAA; tbl[4].eop = 6'h21;
      tbl[5] = tbl[4]; tbl[5].exw = 0;
      tbl[5].ea = 32'hBB; tbl[5].eb = 32'hBB; tbl[5].est = 32'hBB;
      tbl[6] = mkv(6'h00, 6'h21, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[6].exw = 1; tbl[6].exa = 0; tbl[6].exd = 32'hFF; tbl[6].eop = 6'h21;
      tbl[7] = mkv(6'h2B, 0, 0, 16'hFFFC, 4, 6, 32'h100, 32'h7);
      tbl[7].rw = 0; tbl[7].mw = 1;
      tbl[7].mww = 1; tbl[7].mwa = 6; tbl[7].mwd = 32'h55;
      tbl[7].ea = 32'h100; tbl[7].eb = 32'hFFFF_FFFC; tbl[7].est = 32'h55; tbl[7].eop = 6'h21;
      tbl[8] = mkv(6'h00, 6'h04, 0, 0, 1, 2, 32'h23, 32'hF0);
      tbl[8].ea = 32'hF0; tbl[8].eb = 32'h3; tbl[8].eop = 6'h04;
      tbl[9] = mkv(6'h00, 6'h03, 7, 0, 0, 2, 32'h0, 32'h8000_0000);
      tbl[9].regdst = 1; tbl[9].rd = 9; tbl[9].ewr = 9;
      tbl[9].ea = 32'h8000_0000; tbl[9].eb = 32'h7; tbl[9].eop = 6'h03;

      // Power-on reset
      vx = mkv(0, 0, 0, 0, 0, 0, 0, 0);
      drive_dec(vx); drive_fwd(vx); i_valid = 0;
      i_stall = 0; i_flush = 0; i_reset = 1;
      repeat (2) @(posedge i_clk);
      #1 i_reset = 0; #1;
      check_zero("reset");

      // Reset mid-stream after an ADD
      v = mkv(6'h00, 6'h20, 0, 0, 1, 2, 32'h5, 32'h6);
      v.ea = 32'h5; v.eb = 32'h6; v.eop = 6'h20;
      load_vec(v, "add");
      i_reset = 1; drive_fwd(vx);
      @(posedge i_clk); #1 i_reset = 0; #1;
      check_zero("midreset");

      for (int k = 0; k < 10; k++) load_vec(tbl[k], $sformatf("tbl%0d", k));

      // Stall for two cycles while the decode inputs change
      vs = mkv(6'h00, 6'h22, 0, 0, 4, 5, 32'h1234, 32'h0FF0);
      vs.mw = 1; vs.mr = 1; vs.mt = 1; vs.regdst = 1; vs.rd = 12;
      vs = ref_model(vs);
      load_vec(vs, "prestall");
      i_stall = 1;
      for (int c = 0; c < 2; c++) begin
         drive_dec(tbl[c]);
         @(posedge i_clk); #2;
         check_out(vs, $sformatf("stall%0d", c));
      end
      // Flush together with stall: bubble wins
      i_flush = 1;
      @(posedge i_clk); #1 i_flush = 0; i_stall = 0; #1;
      chk("flush.ctrl", {27'd0, o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg}, 32'd0);

      // Randomized vectors against the reference model
      for (int n = 0; n < 300; n++) begin
         int sel;
         sel = $urandom_range(0, 9);
         v.op = (sel == 9) ? 6'($urandom) : ops_list[sel];
         v.funct = 6'($urandom); v.shamt = 5'($urandom); v.imm = 16'($urandom);
         v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
         v.rd = 5'($urandom); v.rsd = $urandom; v.rtd = $urandom;
         v.regdst = 1'($urandom); v.rw = 1'($urandom); v.mr = 1'($urandom);
         v.mw = 1'($urandom); v.mt = 1'($urandom);
         v.exw = 1'($urandom); v.exa = 5'($urandom_range(0, 3)); v.exd = $urandom;
         v.mww = 1'($urandom); v.mwa = 5'($urandom_range(0, 3)); v.mwd = $urandom;
         v = ref_model(v);
         load_vec(v, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline stage between instruction decode and the execute-stage ALU.
- Registers the decode fields and control bits once per cycle, with stall (hold) and flush (bubble) control.
- In the following cycle, resolves EX/MEM and MEM/WB forwarding and builds the ALU operand pair and ALU operation code.
- Drives the ALU inputs directly and passes write-back and memory control on to EX/MEM.

Parameters:
- SIZEDATA, 32, datapath width.
- SIZEOP, 6, opcode/funct and ALU operation width.
- SIZEREG, 5, register-address width.
- SIZEIMM, 16, immediate width.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  hold all stage registers.
- i_flush  in  1  load a bubble.
- i_valid  in  1  decode slot holds a real instruction.
- i_opcode  in  SIZEOP  instruction [31:26].
- i_funct  in  SIZEOP  instruction [5:0].
- i_shamt  in  SIZEREG  instruction [10:6].
- i_imm  in  SIZEIMM  instruction [15:0].
- i_rs_addr, i_rt_addr, i_rd_addr  in  SIZEREG  register addresses.
- i_rs_data, i_rt_data  in  SIZEDATA  register-file read data.
- i_regdst, i_regwrite, i_memread, i_memwrite, i_memtoreg  in  1  decode control bits.
- i_exmem_regwrite  in  1  EX/MEM writes a register.
- i_exmem_addr  in  SIZEREG  EX/MEM destination register.
- i_exmem_data  in  SIZEDATA  EX/MEM result.
- i_memwb_regwrite  in  1  MEM/WB writes a register.
- i_memwb_addr  in  SIZEREG  MEM/WB destination register.
- i_memwb_data  in  SIZEDATA  MEM/WB result.
- o_alu_datoa, o_alu_datob  out  SIZEDATA  ALU operands.
- o_alu_opcode  out  SIZEOP  ALU operation select.
- o_store_data  out  SIZEDATA  forwarded rt value, for SW.
- o_wr_addr  out  SIZEREG  destination register.
- o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg  out  1  control passed to EX/MEM.

Behaviour:
- Reset (i_reset=1 at an edge): every stage register is cleared to 0. All outputs then read 0, including o_alu_opcode=000000 and operands 0; the stage holds a bubble.
- Register update priority per edge: reset > flush > stall > load.
  - Flush: clears o_valid, o_regwrite, o_memread, o_memwrite and o_memtoreg. Data fields may keep or clear their values; downstream must ignore them.
  - Stall: all registers hold their value.
  - Load: all i_* decode fields are captured.
  - Flush together with stall: flush wins.
- Latency:
  - Fields presented in cycle N drive the ALU operands in cycle N+1.
  - Forwarding inputs are sampled live in cycle N+1; they are not registered.
- Forwarding, applied separately for rs and rt:
  - Rule 1: if exmem_regwrite is set, exmem_addr equals the register, and the address is nonzero, use exmem_data.
  - Rule 2: otherwise, if the same conditions hold for memwb, use memwb_data.
  - Rule 3: otherwise use the registered register-file data.
  - Register 0 is never forwarded. EX/MEM has priority over MEM/WB.
- Operand and operation selection, from the registered opcode/funct (rs', rt' are the forwarded values):
  - R-type (opcode 000000), alu_opcode = funct in every case:
    - SLL/SRL/SRA: datoa = rt', datob = zero-extended shamt.
    - SLLV/SRLV/SRAV: datoa = rt', datob = zero-extended rs'[4:0].
    - All other funct values: datoa = rs', datob = rt'.
  - ADDI/SLTI: alu_opcode = opcode, datoa = rs', datob = sign-extended imm.
  - ANDI/ORI/XORI: alu_opcode = opcode, datoa = rs', datob = zero-extended imm.
  - LUI: alu_opcode = 001111, datoa = zero-extended imm, datob = 16.
  - LW (100011) and SW (101011): alu_opcode = ADDU (100001), datoa = rs', datob = sign-extended imm.
  - Any other opcode: alu_opcode = 111111, so the ALU outputs 0. Control passes through unchanged.
- o_store_data = rt' in every case.
- o_wr_addr = regdst ? rd : rt.
- The selection logic is purely combinational from the registers and forwarding inputs; there are no latches.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: RTYPE, ADDI, ANDI, ORI, XORI, LUI, SLTI, LW, SW;
  - funct/ALU-operation constants: SLL through SLT and ADDU;
  - the width constants.
- One combinational sub-module, forwarding_unit, instantiated once for rs and once for rt. Inputs: register address, register-file data, both forward ports. Output: the selected value.

Test Plan:
- Reset mid-stream: load ADD, then assert i_reset for one edge → all outputs 0, o_valid=0. The next load works normally.
- Immediate and shift selection:
  - ADDI with rs=5, data 0x00000010, imm 0xFFFF → datoa=0x10, datob=0xFFFFFFFF, opcode 001000.
  - ORI with the same imm → datob=0x0000FFFF.
  - LUI imm 0x1234 → datoa=0x1234, datob=16.
  - SLL with rt data 0x1, shamt 4 → datoa=1, datob=4, opcode 000000.
- Forwarding priority: ADDU rs=rt=3 with register-file data 0x1; both EX/MEM and MEM/WB write r3, with 0xAA and 0xBB → both operands 0xAA. Remove EX/MEM → both 0xBB.
- Register 0: ADDU rs=0, register-file data 0, EX/MEM writes r0 with 0xFF → datoa stays 0.
- Stall/flush:
  - Stall for 2 cycles while the inputs change → outputs unchanged.
  - Flush with stall in the same cycle → o_valid=0, o_regwrite=0, o_memwrite=0.
- Memory ops: SW with rs data 0x100, imm 0xFFFC, rt forwarded 0x55 from MEM/WB → opcode 100001, datob=0xFFFFFFFC, o_store_data=0x55, o_memwrite=1.
